// File: rtl/ahb_slave_port_arbiter_n_if.sv
// Bus bundle between the masters' request side and the slave-port arbiter.
// The master modport drives requests; the slave modport is the arbiter's view.
interface ahb_slave_port_arbiter_n_if #(
  parameter int NUM_MASTERS = 2
);
  localparam int IDX_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] REQ;
  logic [NUM_MASTERS-1:0] MASTLOCK;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] SEL;
  logic [IDX_W-1:0]       OWNER;
  logic                   LOCK_ACTIVE;
  logic                   LOCK_TO_ERR;

  modport master (
    output REQ, MASTLOCK, HREADY,
    input  SEL, OWNER, LOCK_ACTIVE, LOCK_TO_ERR
  );

  modport slave (
    input  REQ, MASTLOCK, HREADY,
    output SEL, OWNER, LOCK_ACTIVE, LOCK_TO_ERR
  );
endinterface

// File: rtl/ahb_slave_port_arbiter_n.sv
// N-master arbiter for one AHB slave port: round-robin or fixed priority,
// with HMASTLOCK sequences and an optional idle-lock timeout.
module ahb_slave_port_arbiter_n #(
  parameter int NUM_MASTERS  = 2,
  parameter int ARB_MODE     = 0,
  parameter int LOCK_TIMEOUT = 0
) (
  input logic                      HCLK,
  input logic                      HRESETN,
  ahb_slave_port_arbiter_n_if.slave bus
);
  localparam int IDX_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] K_RESET  = IDX_W'(NUM_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DATA      = 2'd1,
    ST_LOCK      = 2'd2,
    ST_LOCK_DATA = 2'd3
  } state_t;

  state_t                 state_r, state_nxt_s, st_eff_s;
  logic [IDX_W-1:0]       k_r, k_nxt_s, k_eff_s;
  logic [IDX_W-1:0]       win_s, cand_s;
  logic                   win_found_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic                   idle_lock_s, timeout_s;
  logic                   lock_to_err_r, lock_active_r;
  logic [NUM_MASTERS-1:0] sel_s;

  // An owner index beyond the last master is recovered as IDLE with the reset index
  always_comb begin
    if (int'(k_r) >= NUM_MASTERS) begin
      st_eff_s = ST_IDLE;
      k_eff_s  = K_RESET;
    end else begin
      st_eff_s = state_r;
      k_eff_s  = k_r;
    end
  end

  // Winner search: upward from K+1 with wrap (round-robin) or from index 0 (fixed)
  always_comb begin
    win_found_s = 1'b0;
    win_s       = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_s      = (ARB_MODE == 0) ? IDX_W'((int'(k_eff_s) + i + 1) % NUM_MASTERS) : IDX_W'(i);
      win_s       = (!win_found_s && bus.REQ[cand_s]) ? cand_s : win_s;
      win_found_s = win_found_s | bus.REQ[cand_s];
    end
  end

  assign idle_lock_s = (st_eff_s == ST_LOCK) && bus.MASTLOCK[k_eff_s] && !bus.REQ[k_eff_s];
  assign timeout_s   = (LOCK_TIMEOUT > 0) && idle_lock_s && (cnt_r == CNT_LAST);
  assign cnt_nxt_s   = idle_lock_s ? ((cnt_r >= CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1)) : '0;

  // State register plus the registered status outputs
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_r       <= ST_IDLE;
      k_r           <= K_RESET;
      cnt_r         <= '0;
      lock_to_err_r <= 1'b0;
      lock_active_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      k_r           <= k_nxt_s;
      cnt_r         <= cnt_nxt_s;
      lock_to_err_r <= timeout_s;
      lock_active_r <= (state_nxt_s == ST_LOCK) || (state_nxt_s == ST_LOCK_DATA);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = st_eff_s;
    k_nxt_s     = k_eff_s;
    case (st_eff_s)
      ST_IDLE: begin
        if (win_found_s) begin
          k_nxt_s = win_s;
          if (bus.MASTLOCK[win_s]) begin
            state_nxt_s = ST_LOCK;
          end else if (bus.HREADY) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        state_nxt_s = bus.HREADY ? ST_IDLE : ST_DATA;
      end
      ST_LOCK: begin
        // Other masters' requests are ignored for as long as the owner holds the lock
        if (!bus.MASTLOCK[k_eff_s]) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.REQ[k_eff_s]) begin
          state_nxt_s = bus.HREADY ? ST_LOCK : ST_LOCK_DATA;
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOCK;
        end
      end
      ST_LOCK_DATA: begin
        state_nxt_s = bus.HREADY ? ST_LOCK : ST_LOCK_DATA;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        k_nxt_s     = K_RESET;
      end
    endcase
  end

  // Select output; a locked grant waits one cycle so SEL stays low on acquisition
  always_comb begin
    sel_s = '0;
    case (st_eff_s)
      ST_IDLE: begin
        if (win_found_s && !bus.MASTLOCK[win_s]) begin
          sel_s[win_s] = 1'b1;
        end else begin
          sel_s = '0;
        end
      end
      ST_DATA, ST_LOCK_DATA: begin
        sel_s[k_eff_s] = 1'b1;
      end
      ST_LOCK: begin
        if (bus.MASTLOCK[k_eff_s] && bus.REQ[k_eff_s]) begin
          sel_s[k_eff_s] = 1'b1;
        end else begin
          sel_s = '0;
        end
      end
      default: begin
        sel_s = '0;
      end
    endcase
  end

  assign bus.SEL         = sel_s;
  assign bus.OWNER       = k_r;
  assign bus.LOCK_ACTIVE = lock_active_r;
  assign bus.LOCK_TO_ERR = lock_to_err_r;
endmodule

// File: tb/tb_ahb_slave_port_arbiter_n.sv
// Directed bench for ahb_slave_port_arbiter_n: several parameterisations side by
// side, each scenario task checks its own hand-computed expectations.
module tb_ahb_slave_port_arbiter_n;
  logic HCLK = 1'b0;
  logic HRESETN;
  int   tests = 0;
  int   fails = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_port_arbiter_n_if #(.NUM_MASTERS(4)) if_rr ();
  ahb_slave_port_arbiter_n_if #(.NUM_MASTERS(4)) if_fp ();
  ahb_slave_port_arbiter_n_if #(.NUM_MASTERS(2)) if_n2 ();
  ahb_slave_port_arbiter_n_if #(.NUM_MASTERS(4)) if_to ();

  ahb_slave_port_arbiter_n #(.NUM_MASTERS(4), .ARB_MODE(0), .LOCK_TIMEOUT(0))
    dut_rr (.HCLK(HCLK), .HRESETN(HRESETN), .bus(if_rr.slave));
  ahb_slave_port_arbiter_n #(.NUM_MASTERS(4), .ARB_MODE(1), .LOCK_TIMEOUT(0))
    dut_fp (.HCLK(HCLK), .HRESETN(HRESETN), .bus(if_fp.slave));
  ahb_slave_port_arbiter_n #(.NUM_MASTERS(2), .ARB_MODE(0), .LOCK_TIMEOUT(0))
    dut_n2 (.HCLK(HCLK), .HRESETN(HRESETN), .bus(if_n2.slave));
  ahb_slave_port_arbiter_n #(.NUM_MASTERS(4), .ARB_MODE(0), .LOCK_TIMEOUT(4))
    dut_to (.HCLK(HCLK), .HRESETN(HRESETN), .bus(if_to.slave));

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_quiet();
    if_rr.REQ = 4'b0000; if_rr.MASTLOCK = 4'b0000; if_rr.HREADY = 1'b1;
    if_fp.REQ = 4'b0000; if_fp.MASTLOCK = 4'b0000; if_fp.HREADY = 1'b1;
    if_n2.REQ = 2'b00;   if_n2.MASTLOCK = 2'b00;   if_n2.HREADY = 1'b1;
    if_to.REQ = 4'b0000; if_to.MASTLOCK = 4'b0000; if_to.HREADY = 1'b1;
  endtask

  task automatic test_reset();
    HRESETN = 1'b0;
    drive_quiet();
    tick();
    tick();
    tests++; if (if_rr.SEL !== 4'b0000) begin fails++; $display("FAIL reset_sel got %b want 0000", if_rr.SEL); end
    tests++; if (if_rr.OWNER !== 2'd3) begin fails++; $display("FAIL reset_owner got %0d want 3", if_rr.OWNER); end
    tests++; if (if_rr.LOCK_ACTIVE !== 1'b0) begin fails++; $display("FAIL reset_lock_active got %b want 0", if_rr.LOCK_ACTIVE); end
    tests++; if (if_rr.LOCK_TO_ERR !== 1'b0) begin fails++; $display("FAIL reset_lock_to_err got %b want 0", if_rr.LOCK_TO_ERR); end
    tests++; if (if_n2.OWNER !== 1'b1) begin fails++; $display("FAIL reset_owner_n2 got %0d want 1", if_n2.OWNER); end
    // SEL follows the IDLE rules even while reset is held
    if_rr.REQ = 4'b1111;
    #1;
    tests++; if (if_rr.SEL !== 4'b0001) begin fails++; $display("FAIL reset_sel_req got %b want 0001", if_rr.SEL); end
    if_rr.REQ = 4'b0000;
    #1;
    HRESETN = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_sel [5];
    exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    if_rr.REQ = 4'b1111;
    if_rr.HREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (if_rr.SEL !== exp_sel[i]) begin fails++; $display("FAIL rr_sel[%0d] got %b want %b", i, if_rr.SEL, exp_sel[i]); end
      tick();
    end
    if_rr.REQ = 4'b0000;
    #1;
    tests++; if (if_rr.OWNER !== 2'd0) begin fails++; $display("FAIL rr_owner got %0d want 0", if_rr.OWNER); end
    tick();
  endtask

  task automatic test_fixed_priority();
    if_fp.REQ = 4'b1010;
    if_fp.HREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (if_fp.SEL !== 4'b0010) begin fails++; $display("FAIL fp_sel[%0d] got %b want 0010", i, if_fp.SEL); end
      tick();
    end
    if_fp.REQ = 4'b0000;
    #1;
    tests++; if (if_fp.OWNER !== 2'd1) begin fails++; $display("FAIL fp_owner got %0d want 1", if_fp.OWNER); end
    tick();
  endtask

  task automatic test_data_wait();
    logic [1:0] exp_sel [5];
    logic [1:0] req_seq [5];
    logic       rdy_seq [5];
    exp_sel = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    req_seq = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    rdy_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if_n2.REQ = req_seq[i];
      if_n2.HREADY = rdy_seq[i];
      #1;
      tests++; if (if_n2.SEL !== exp_sel[i]) begin fails++; $display("FAIL wait_sel[%0d] got %b want %b", i, if_n2.SEL, exp_sel[i]); end
      tick();
    end
    if_n2.REQ = 2'b00;
    #1;
    tests++; if (if_n2.OWNER !== 1'b1) begin fails++; $display("FAIL wait_owner got %0d want 1", if_n2.OWNER); end
    tick();
  endtask

  task automatic test_lock();
    if_rr.REQ = 4'b0100; if_rr.MASTLOCK = 4'b0100; if_rr.HREADY = 1'b1;
    #1;
    tests++; if (if_rr.SEL !== 4'b0000) begin fails++; $display("FAIL lock_acq_sel got %b want 0000", if_rr.SEL); end
    tick();
    tests++; if (if_rr.LOCK_ACTIVE !== 1'b1) begin fails++; $display("FAIL lock_active got %b want 1", if_rr.LOCK_ACTIVE); end
    tests++; if (if_rr.OWNER !== 2'd2) begin fails++; $display("FAIL lock_owner got %0d want 2", if_rr.OWNER); end
    tests++; if (if_rr.SEL !== 4'b0100) begin fails++; $display("FAIL lock_sel got %b want 0100", if_rr.SEL); end
    tick();
    if_rr.REQ = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (if_rr.SEL !== 4'b0000) begin fails++; $display("FAIL lock_hold_sel[%0d] got %b want 0000", i, if_rr.SEL); end
      tick();
    end
    if_rr.MASTLOCK = 4'b0000;
    #1;
    tests++; if (if_rr.SEL !== 4'b0000) begin fails++; $display("FAIL lock_release_sel got %b want 0000", if_rr.SEL); end
    tick();
    tests++; if (if_rr.LOCK_ACTIVE !== 1'b0) begin fails++; $display("FAIL lock_release_active got %b want 0", if_rr.LOCK_ACTIVE); end
    tests++; if (if_rr.SEL !== 4'b1000) begin fails++; $display("FAIL lock_next_grant got %b want 1000", if_rr.SEL); end
    tick();
    if_rr.REQ = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    if_to.REQ = 4'b0010; if_to.MASTLOCK = 4'b0010; if_to.HREADY = 1'b1;
    #1;
    tests++; if (if_to.SEL !== 4'b0000) begin fails++; $display("FAIL to_acq_sel got %b want 0000", if_to.SEL); end
    tick();
    if_to.REQ = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (if_to.SEL !== 4'b0000) begin fails++; $display("FAIL to_idle_sel[%0d] got %b want 0000", i, if_to.SEL); end
      tests++; if (if_to.LOCK_TO_ERR !== 1'b0) begin fails++; $display("FAIL to_err_early[%0d] got %b want 0", i, if_to.LOCK_TO_ERR); end
      tick();
    end
    tests++; if (if_to.LOCK_TO_ERR !== 1'b1) begin fails++; $display("FAIL to_err_pulse got %b want 1", if_to.LOCK_TO_ERR); end
    tests++; if (if_to.LOCK_ACTIVE !== 1'b0) begin fails++; $display("FAIL to_lock_active got %b want 0", if_to.LOCK_ACTIVE); end
    tests++; if (if_to.SEL !== 4'b0100) begin fails++; $display("FAIL to_grant1 got %b want 0100", if_to.SEL); end
    tick();
    tests++; if (if_to.LOCK_TO_ERR !== 1'b0) begin fails++; $display("FAIL to_err_width got %b want 0", if_to.LOCK_TO_ERR); end
    tests++; if (if_to.SEL !== 4'b0001) begin fails++; $display("FAIL to_grant2 got %b want 0001", if_to.SEL); end
    if_to.REQ = 4'b0000; if_to.MASTLOCK = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_lock();
    if_rr.REQ = 4'b0001; if_rr.MASTLOCK = 4'b0001; if_rr.HREADY = 1'b1;
    #1;
    tests++; if (if_rr.SEL !== 4'b0000) begin fails++; $display("FAIL rst_acq_sel got %b want 0000", if_rr.SEL); end
    tick();
    if_rr.HREADY = 1'b0;
    tick();
    tests++; if (if_rr.LOCK_ACTIVE !== 1'b1) begin fails++; $display("FAIL rst_pre_active got %b want 1", if_rr.LOCK_ACTIVE); end
    tests++; if (if_rr.SEL !== 4'b0001) begin fails++; $display("FAIL rst_pre_sel got %b want 0001", if_rr.SEL); end
    HRESETN = 1'b0;
    if_rr.REQ = 4'b0000;
    #1;
    tests++; if (if_rr.SEL !== 4'b0000) begin fails++; $display("FAIL rst_mid_sel got %b want 0000", if_rr.SEL); end
    tests++; if (if_rr.OWNER !== 2'd3) begin fails++; $display("FAIL rst_mid_owner got %0d want 3", if_rr.OWNER); end
    tests++; if (if_rr.LOCK_ACTIVE !== 1'b0) begin fails++; $display("FAIL rst_mid_active got %b want 0", if_rr.LOCK_ACTIVE); end
    if_rr.MASTLOCK = 4'b0000; if_rr.REQ = 4'b1111; if_rr.HREADY = 1'b1;
    HRESETN = 1'b1;
    #1;
    tests++; if (if_rr.SEL !== 4'b0001) begin fails++; $display("FAIL rst_first_grant got %b want 0001", if_rr.SEL); end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_data_wait();
    test_lock();
    test_timeout();
    test_reset_mid_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ahb_slave_port_arbiter_n.md
AHB_SLAVE_PORT_ARBITER_N -- requirements
Module: ahb_slave_port_arbiter_n

Interface
REQ-001 SHALL provide the following parameters:
- NUM_MASTERS, 2, masters sharing this slave port (2..16).
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins.
- LOCK_TIMEOUT, 0, idle-lock cycles before forced release; 0 disables the timeout.
REQ-002 SHALL define IDX_W = max(1, clog2(NUM_MASTERS)).
REQ-003 SHALL provide the following ports:
- HCLK, input, 1, clock. All state updates occur on the rising edge.
- HRESETN, input, 1, reset: asynchronous, active-low.
- REQ, input, NUM_MASTERS, per-master valid address phase targeting this slave.
- MASTLOCK, input, NUM_MASTERS, per-master HMASTLOCK.
- HREADY, input, 1, slave-port ready; completes the current data phase.
- SEL, output, NUM_MASTERS, one-hot or zero master select. Combinational from state and inputs.
- OWNER, output, IDX_W, index of the registered owner or last-granted master.
- LOCK_ACTIVE, output, 1, high in LOCK and LOCK_DATA.
- LOCK_TO_ERR, output, 1, one-cycle registered pulse on lock timeout.

Function
REQ-004 SHALL implement four states: IDLE, DATA, LOCK and LOCK_DATA. Each state carries an owner/last index K.
REQ-005 SHALL choose the winner W in IDLE as follows:
- ARB_MODE=0: first set REQ bit searching upward from K+1, wrapping modulo NUM_MASTERS.
- ARB_MODE=1: lowest set REQ bit.
REQ-006 SHALL, in IDLE with no REQ set, drive SEL=0 and remain IDLE with K unchanged.
REQ-007 SHALL, in IDLE with W found and MASTLOCK[W]=0, behave as follows:
- Drive SEL=onehot(W).
- If HREADY=1, go to IDLE with K=W.
- If HREADY=0, go to DATA with K=W.
REQ-008 SHALL, in IDLE with W found and MASTLOCK[W]=1, drive SEL=0 and go to LOCK with K=W. This gives one cycle of lock-acquisition latency.
REQ-009 SHALL, in DATA, drive SEL=onehot(K). Go to IDLE (same K) when HREADY=1; otherwise stay in DATA.
REQ-010 SHALL, in LOCK with MASTLOCK[K]=1 and REQ[K]=1, behave as follows:
- Drive SEL=onehot(K).
- Stay in LOCK if HREADY=1.
- Go to LOCK_DATA if HREADY=0.
REQ-011 SHALL, in LOCK with MASTLOCK[K]=1 and REQ[K]=0, drive SEL=0 and stay in LOCK. Requests from all other masters are ignored.
REQ-012 SHALL, in LOCK with MASTLOCK[K]=0, drive SEL=0 and go to IDLE with K unchanged.
REQ-013 SHALL, in LOCK_DATA, drive SEL=onehot(K). Go to LOCK when HREADY=1; otherwise stay in LOCK_DATA.
REQ-014 SHALL maintain an idle-lock counter as follows:
- Increment each cycle the arbiter is in LOCK with MASTLOCK[K]=1 and REQ[K]=0.
- Clear on any other cycle.
- Saturate at LOCK_TIMEOUT.
REQ-015 SHALL, when LOCK_TIMEOUT>0 and the counter reaches LOCK_TIMEOUT-1 in a qualifying cycle:
- Drive SEL=0.
- Go to IDLE with K unchanged.
- Set LOCK_TO_ERR=1 for exactly the next cycle.
REQ-016 SHALL keep SEL zero or one-hot in every cycle. SEL SHALL never select a master whose REQ is low, except in DATA and LOCK_DATA, where the data phase continues regardless of REQ.
REQ-017 SHALL make OWNER equal the registered K. LOCK_ACTIVE SHALL be registered.
REQ-018 SHALL treat an out-of-range K (for non-power-of-two NUM_MASTERS) as IDLE with K=NUM_MASTERS-1.

Reset
REQ-019 SHALL, while HRESETN=0, hold the following values: state IDLE, K=NUM_MASTERS-1, counter 0, LOCK_TO_ERR=0, LOCK_ACTIVE=0.
REQ-020 SHALL make SEL obey REQ-006/007 during reset. With K=NUM_MASTERS-1, master 0 has first round-robin priority.
REQ-021 SHALL, when HRESETN is asserted mid-transfer, abort any DATA or LOCK state immediately. No pending grant is retained.

Verification
REQ-022 N=4, mode 0, REQ=4'b1111 held, HREADY=1 -> SEL sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-023 N=4, mode 1, REQ=4'b1010, HREADY=1 -> SEL=0010 on every cycle; master 3 is never selected.
REQ-024 N=2, REQ=01, HREADY low for 3 cycles after the grant -> SEL=01 for 4 cycles with the state in DATA. REQ=10 arriving mid-wait is not granted until the cycle after HREADY=1.
REQ-025 N=4, master 2 requests with MASTLOCK[2]=1 -> cycle 0 SEL=0000, cycle 1 SEL=0100, LOCK_ACTIVE=1. REQ=1011 from the other masters yields SEL=0000 until MASTLOCK[2] drops; the next grant then goes to master 3.
REQ-026 LOCK_TIMEOUT=4, lock owner 1 with REQ[1]=0 held -> SEL=0 for 4 cycles. Return to IDLE, LOCK_TO_ERR pulses for 1 cycle, then other masters are granted.
REQ-027 Reset asserted in LOCK_DATA -> SEL=0 with REQ=0, OWNER=NUM_MASTERS-1 and LOCK_ACTIVE=0 immediately; after release with REQ=all-ones, the first SEL is onehot(0).
